// File: rtl/seq_left_shifter.sv
// seq_left_shifter
// Multi-cycle left shift / left rotate unit. One binary stage (WIDTH/2 ... 1)
// is resolved per clock, working on a single accumulator register.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request pulse, sampled only while idle
//   shift_rot  0 = logical left shift (zero fill), 1 = rotate left
//   r          shift amount, 0..WIDTH-1
//   x          operand
//   busy       operation in progress
//   done       one-cycle pulse, y valid
//   y          result, held until the next done
//   carry_out  (only with SEQ_SHL_CARRY_EN defined) last bit shifted out of
//              bit WIDTH-1; 0 when r = 0
//
// Optional feature macro: SEQ_SHL_CARRY_EN
module seq_left_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shift_rot,
  input  logic [SHW-1:0]   r,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
`ifdef SEQ_SHL_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  // Stage index only needs to address SHW stages.
  localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   r_q, r_d;
  logic             rot_q, rot_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             done_q, done_d;
`ifdef SEQ_SHL_CARRY_EN
  logic             cacc_q, cacc_d;
  logic             carry_out_q, carry_out_d;
`endif

  // Every stage result is precomputed from the accumulator; the active stage
  // is then picked by k. Each stage is a fixed-distance shift, so no barrel
  // shifter is built.
  logic [WIDTH-1:0] stage_res  [SHW];
  logic             stage_cout [SHW];

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
      localparam int SH = 2 ** gi;
      assign stage_res[gi] = rot_q
          ? {acc_q[WIDTH-1-SH:0], acc_q[WIDTH-1:WIDTH-SH]}
          : {acc_q[WIDTH-1-SH:0], {SH{1'b0}}};
      // Last bit to leave the top when this stage applies.
      assign stage_cout[gi] = acc_q[WIDTH-SH];
    end
  endgenerate

  logic             apply;
  logic             last;
  logic [WIDTH-1:0] step_res;

  always_comb begin
    apply    = r_q[k_q];
    last     = (k_q == '0);
    step_res = apply ? stage_res[k_q] : acc_q;
  end

  // State register (plus datapath flops)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      rot_q   <= 1'b0;
      y_q     <= '0;
      done_q  <= 1'b0;
`ifdef SEQ_SHL_CARRY_EN
      cacc_q      <= 1'b0;
      carry_out_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      rot_q   <= rot_d;
      y_q     <= y_d;
      done_q  <= done_d;
`ifdef SEQ_SHL_CARRY_EN
      cacc_q      <= cacc_d;
      carry_out_q <= carry_out_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    k_d    = k_q;
    acc_d  = acc_q;
    r_d    = r_q;
    rot_d  = rot_q;
    y_d    = y_q;
    done_d = 1'b0;
`ifdef SEQ_SHL_CARRY_EN
    cacc_d      = cacc_q;
    carry_out_d = carry_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = x;
          r_d   = r;
          rot_d = shift_rot;
          k_d   = KW'(SHW - 1);
`ifdef SEQ_SHL_CARRY_EN
          cacc_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        acc_d = step_res;
        k_d   = k_q - KW'(1);
`ifdef SEQ_SHL_CARRY_EN
        if (apply) cacc_d = stage_cout[k_q];
`endif
        if (last) begin
          y_d    = step_res;
          done_d = 1'b1;
`ifdef SEQ_SHL_CARRY_EN
          carry_out_d = cacc_d;
`endif
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign y    = y_q;
`ifdef SEQ_SHL_CARRY_EN
  assign carry_out = carry_out_q;
`endif

endmodule

// File: doc/seq_left_shifter.md
Name: seq_left_shifter

Overview:
- Multi-cycle left shift / left rotate unit for the 32-bit processor datapath.
- It is the left-direction counterpart to the combinational right shift/rotate stages.
- Resolves one binary stage (16, 8, 4, 2, 1) per clock, iterating over a single stage register instead of a 5-level mux tree.
- Uses a start/busy/done handshake toward the ALU control FSM.

Parameters:
- WIDTH, 32, data width; must be a power of 2.
- SHW, 5, shift-amount width; must satisfy 2**SHW == WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when idle.
- shift_rot  input  1  mode: 0 = logical left shift with zero fill, 1 = rotate left.
- r  input  SHW  shift amount, 0..WIDTH-1.
- x  input  WIDTH  operand.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; y is valid.
- y  output  WIDTH  result; holds until the next done.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, y=0, internal accumulator=0, stage index=0; carry_out=0 when present.
- States:
  - IDLE: waiting for start.
  - SHIFT: stage index k counts SHW-1 down to 0.
- IDLE to SHIFT: at an edge with start=1, capture x into the accumulator, and capture r and shift_rot. Set k=SHW-1 and busy=1.
- SHIFT, each edge:
  - If captured r[k]=1, the accumulator becomes accumulator shifted left by 2**k.
  - The low 2**k bits are filled with 0 (shift_rot=0) or with the accumulator's top 2**k bits (shift_rot=1).
  - If r[k]=0, the accumulator is unchanged.
  - Then k decrements.
- SHIFT exit (edge where k=0):
  - y takes the final stage result; done=1; busy=0; state returns to IDLE.
- Latency: fixed. Edge E0 captures the operands; done is high in the cycle after edge E0+SHW. r=0 takes the same latency, with y=x.
- done is high for exactly one cycle and deasserts on the next edge unless a new operation completes.
- start while busy=1: ignored. Captured operands do not change; no queueing.
- start in the cycle done=1 is accepted, since the state is IDLE. This gives back-to-back throughput of one result per SHW+1 cycles.
- x, r and shift_rot may change freely after the capture edge.
- Reset mid-operation: aborts immediately; no done pulse; y=0.
- Simultaneous rst and start: rst wins.
- Widths: no arithmetic overflow is possible; bits shifted past bit WIDTH-1 are discarded (shift mode).

Optional Feature:
- Macro: SEQ_SHL_CARRY_EN.
- Defined:
  - Adds output port carry_out, 1 bit, reset 0, updated with y on the done edge.
  - carry_out = last bit shifted out of bit WIDTH-1, i.e. x[WIDTH-r] for r>0.
  - Tracked per stage: when stage k applies, carry = accumulator[WIDTH-2**k] before the shift.
  - In rotate mode the value is identical to y[0].
  - r=0 gives carry_out=0.
- Undefined: no carry_out port, no carry register. All other behaviour is identical.

Test Plan:
1. x=0x00000001, r=4, shift_rot=0, start pulse -> busy for 5 cycles; done pulse in the 6th cycle with y=0x00000010, carry_out=0.
2. x=0x8000000F, r=4, shift_rot=1 -> y=0x000000F8, carry_out=0 (y[0]). Same x with shift_rot=0 -> y=0x000000F0, carry_out=0.
3. x=0xFFFFFFFF, r=31, shift_rot=0 -> y=0x80000000, carry_out=1. Same with r=0 -> y=0xFFFFFFFF after the same 6-cycle latency, carry_out=0.
4. start x=0x12345678, r=8, rotate; at cycle 2 assert start with x=0, r=1 -> second request ignored; y=0x34567812, exactly one done.
5. Start an op; assert rst at cycle 3 -> next cycle busy=0, done=0, y=0, and no done pulse ever follows.
6. Start op A (x=0x1, r=1, shift), then start op B (x=0x1, r=31, shift) in A's done cycle -> done for A with y=0x2; done for B 6 cycles later with y=0x80000000.
